frame_sync_deser: RTL and testbench

- Sits directly downstream of the CDR top. Consumes the symbol strobe `sample_en` and hard decision `d_bb`.
- Finds a periodic sync byte in the recovered bit stream using a HUNT/VERIFY/LOCKED state machine.
- Deserializes payload bits MSB-first into bytes, with a valid strobe and a start-of-frame marker.
- Reports frame lock and a saturating sync-error count to the link layer.

---
 rtl/frame_sync_deser.sv | 140 ++++++++++++++
 tb/tb_frame_sync_deser.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_deser.sv
// Frame synchroniser / deserialiser behind the CDR: hunts for a periodic sync
// byte, verifies it over VERIFY_N frames, then streams payload bytes MSB-first.
module frame_sync_deser #(
  parameter logic [7:0] SYNC_WORD = 8'h47,
  parameter int         FRAME_LEN = 16,
  parameter int         VERIFY_N  = 3,
  parameter int         MISS_N    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic       d_bb,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       sof,
  output logic       locked,
  output logic [1:0] state,
  output logic [7:0] sync_err_cnt
);

  localparam int FB = (FRAME_LEN + 1) * 8;
  localparam int CW = $clog2(FB);
  localparam logic [CW-1:0] LAST       = CW'(FB - 1);
  localparam logic [3:0]    VERIFY_TGT = 4'(VERIFY_N);
  localparam logic [3:0]    MISS_TGT   = 4'(MISS_N);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            bit_stb;
  logic [6:0]      sr;
  logic [2:0]      fill;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [3:0]      hits_q, hits_d, miss_q, miss_d;
  logic [3:0]      hits_inc, miss_inc;
  logic [7:0]      w;
  logic            sync_ok, at_end;
  logic            emit, emit_sof, err_inc;

  // Candidate word is only trusted once seven earlier bits are in the shifter.
  assign w        = {sr, d_bb};
  assign sync_ok  = (fill == 3'd7) && (w == SYNC_WORD);
  assign at_end   = (bit_cnt_q == LAST);
  assign hits_inc = hits_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;
  assign state    = state_q;

  // byte_valid is a one-cycle strobe with no backpressure: byte_out is new
  // exactly on cycles where byte_valid is high and holds otherwise.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    hits_d    = hits_q;
    miss_d    = miss_q;
    emit      = 1'b0;
    emit_sof  = 1'b0;
    err_inc   = 1'b0;
    if (bit_stb) begin
      case (state_q)
        HUNT: begin
          if (sync_ok) begin
            bit_cnt_d = '0;
            hits_d    = 4'd1;
            miss_d    = 4'd0;
            state_d   = (VERIFY_N == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (at_end) begin
            bit_cnt_d = '0;
            if (sync_ok) begin
              hits_d = hits_inc;
              if (hits_inc == VERIFY_TGT) begin
                state_d = LOCKED;
                miss_d  = 4'd0;
              end
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (at_end) begin
            bit_cnt_d = '0;
            if (sync_ok) begin
              miss_d = 4'd0;
            end else begin
              miss_d  = miss_inc;
              err_inc = 1'b1;
              if (miss_inc == MISS_TGT) state_d = HUNT;
            end
          end else if (bit_cnt_q[2:0] == 3'd7) begin
            emit     = 1'b1;
            emit_sof = (bit_cnt_q == CW'(7));
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_stb      <= 1'b0;
      sr           <= '0;
      fill         <= '0;
      state_q      <= HUNT;
      bit_cnt_q    <= '0;
      hits_q       <= '0;
      miss_q       <= '0;
      byte_out     <= '0;
      byte_valid   <= 1'b0;
      sof          <= 1'b0;
      locked       <= 1'b0;
      sync_err_cnt <= '0;
    end else begin
      bit_stb <= sample_en;
      if (bit_stb) begin
        sr <= w[6:0];
        if (fill != 3'd7) fill <= fill + 3'd1;
      end
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      hits_q     <= hits_d;
      miss_q     <= miss_d;
      byte_valid <= emit;
      sof        <= emit_sof;
      if (emit) byte_out <= w;
      locked <= (state_d == LOCKED);
      if (err_inc && sync_err_cnt != 8'hFF) sync_err_cnt <= sync_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_sync_deser.sv
// Bench for frame_sync_deser: bit-level stimulus, a frame-level reference
// model over the sent bit stream, and a per-captured-bit trace scoreboard.
module tb_frame_sync_deser;

  localparam logic [7:0] SYNC      = 8'h47;
  localparam logic [7:0] BAD_SYNC  = 8'h46;
  localparam int         FRAME_LEN = 16;
  localparam int         VERIFY_N  = 3;
  localparam int         MISS_N    = 2;
  localparam int         FB        = (FRAME_LEN + 1) * 8;
  localparam logic [1:0] ST_HUNT   = 2'b00;
  localparam logic [1:0] ST_VERIFY = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_en = 1'b0;
  logic       d_bb = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       sof;
  logic       locked;
  logic [1:0] state;
  logic [7:0] sync_err_cnt;

  frame_sync_deser #(
    .SYNC_WORD(SYNC), .FRAME_LEN(FRAME_LEN), .VERIFY_N(VERIFY_N), .MISS_N(MISS_N)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .d_bb(d_bb),
    .byte_out(byte_out), .byte_valid(byte_valid), .sof(sof),
    .locked(locked), .state(state), .sync_err_cnt(sync_err_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stray_cnt = 0;

  // Trace entry per captured bit: [20:19] state, [18] locked, [17] byte_valid,
  // [16] sof, [15:8] byte_out (masked when no byte), [7:0] sync_err_cnt.
  logic        bits_q[$];
  logic [20:0] obs_q[$];
  logic [20:0] exp_q[$];
  logic [7:0]  ref_bytes_q[$];

  // A bit is captured on the second rising edge after its sample_en.
  logic se_d1, se_d2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      se_d1 <= 1'b0;
      se_d2 <= 1'b0;
    end else begin
      se_d1 <= sample_en;
      se_d2 <= se_d1;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (se_d2 === 1'b1)
        obs_q.push_back({state, locked, byte_valid, sof,
                         byte_valid ? byte_out : 8'h00, sync_err_cnt});
      else if (byte_valid === 1'b1 || sof === 1'b1)
        stray_cnt++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] win(input int idx);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v = {v[6:0], bits_q[idx - 7 + k]};
    return v;
  endfunction

  // Works frame by frame: scan for a sync, then jump FB bits to each
  // following sync position; payload bytes end at anchor + 8*j.
  task automatic run_model();
    int n;
    int set_st[$];
    int set_err[$];
    logic bv[$];
    logic sf[$];
    logic [7:0] by[$];
    int p, a, hits, miss, err, cur_st, cur_err;
    bit done;
    n = bits_q.size();
    for (int i = 0; i < n; i++) begin
      set_st.push_back(-1); set_err.push_back(-1);
      bv.push_back(1'b0); sf.push_back(1'b0); by.push_back(8'h00);
    end
    p = 7; err = 0; done = 1'b0;
    while (!done && p < n) begin
      while (p < n && win(p) != SYNC) p++;
      if (p >= n) break;
      a = p; hits = 1;
      set_st[a] = (VERIFY_N == 1) ? 2 : 1;
      while (!done && hits < VERIFY_N) begin
        a += FB;
        if (a >= n) done = 1'b1;
        else if (win(a) == SYNC) begin
          hits++;
          if (hits == VERIFY_N) set_st[a] = 2;
        end else begin
          set_st[a] = 0;
          break;
        end
      end
      if (done) break;
      if (hits < VERIFY_N) begin
        p = a + 1;
        continue;
      end
      miss = 0;
      while (!done && miss < MISS_N) begin
        for (int j = 1; j <= FRAME_LEN; j++) begin
          if (a + 8 * j < n) begin
            bv[a + 8 * j] = 1'b1;
            sf[a + 8 * j] = (j == 1);
            by[a + 8 * j] = win(a + 8 * j);
          end
        end
        a += FB;
        if (a >= n) done = 1'b1;
        else if (win(a) == SYNC) miss = 0;
        else begin
          miss++;
          if (err < 255) err++;
          set_err[a] = err;
          if (miss == MISS_N) set_st[a] = 0;
        end
      end
      p = a + 1;
    end
    exp_q.delete();
    cur_st = 0; cur_err = 0;
    for (int i = 0; i < n; i++) begin
      if (set_st[i] >= 0) cur_st = set_st[i];
      if (set_err[i] >= 0) cur_err = set_err[i];
      exp_q.push_back({2'(cur_st), (cur_st == 2), bv[i], sf[i], by[i], 8'(cur_err)});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_bit(input logic b, input int gap);
    @(negedge clk);
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    d_bb = b;
    bits_q.push_back(b);
    repeat (gap) begin
      @(negedge clk);
      sample_en = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int k = 7; k >= 0; k--)
      send_bit(b[k], (gap < 0) ? int'($urandom_range(0, 2)) : gap);
  endtask

  // mode 0: payload 00..0F, mode 1: random payload, mode 2: all zeros
  task automatic send_frame(input logic [7:0] sync_b, input int mode, input int gap);
    logic [7:0] b;
    send_byte(sync_b, gap);
    for (int j = 0; j < FRAME_LEN; j++) begin
      b = (mode == 0) ? 8'(j) : (mode == 1) ? 8'($urandom) : 8'h00;
      send_byte(b, gap);
    end
  endtask

  task automatic flush();
    @(negedge clk);
    sample_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_en = 1'b0;
    d_bb = 1'b0;
    bits_q.delete();
    obs_q.delete();
    stray_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    n_checks++; if (state !== ST_HUNT) begin n_fail++; $display("FAIL reset_state: got %b expected %b", state, ST_HUNT); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
    n_checks++; if (sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof: got %b expected 0", sof); end
    n_checks++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte_out: got %h expected 00", byte_out); end
    n_checks++; if (sync_err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_err_cnt: got %h expected 00", sync_err_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_and_payload();
    int k;
    do_reset();
    for (int f = 0; f < 6; f++) send_frame(SYNC, 0, 1);
    flush();
    n_checks++; if (obs_q[6][20:19] !== ST_HUNT) begin n_fail++; $display("FAIL lock_pre_sync: got %b expected %b", obs_q[6][20:19], ST_HUNT); end
    n_checks++; if (obs_q[7][20:19] !== ST_VERIFY) begin n_fail++; $display("FAIL lock_first_sync: got %b expected %b", obs_q[7][20:19], ST_VERIFY); end
    n_checks++; if (obs_q[FB+7][20:19] !== ST_VERIFY) begin n_fail++; $display("FAIL lock_second_sync: got %b expected %b", obs_q[FB+7][20:19], ST_VERIFY); end
    n_checks++; if (obs_q[2*FB+7][20:18] !== {ST_LOCKED, 1'b1}) begin n_fail++; $display("FAIL lock_third_sync: got %b expected %b", obs_q[2*FB+7][20:18], {ST_LOCKED, 1'b1}); end
    ref_bytes_q.delete();
    k = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][17]) begin
        n_checks++;
        if (obs_q[i][15:8] !== 8'(k % 16) || obs_q[i][16] !== (k % 16 == 0)) begin
          n_fail++; $display("FAIL lock_byte %0d: got %h sof %b expected %h sof %b", k, obs_q[i][15:8], obs_q[i][16], 8'(k % 16), (k % 16 == 0));
        end
        ref_bytes_q.push_back(obs_q[i][15:8]);
        k++;
      end
    end
    n_checks++; if (k != 64) begin n_fail++; $display("FAIL lock_byte_count: got %0d expected 64", k); end
    n_checks++; if (sync_err_cnt !== 8'h00) begin n_fail++; $display("FAIL lock_err_cnt: got %h expected 00", sync_err_cnt); end
    run_model();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL lock_nbits: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lock_trace bit %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (stray_cnt != 0) begin n_fail++; $display("FAIL lock_stray_pulse: got %0d expected 0", stray_cnt); end
  endtask

  // Continues from the locked stream left by the previous test.
  task automatic test_single_corrupt();
    int from, k;
    from = obs_q.size();
    send_frame(BAD_SYNC, 0, 1);
    send_frame(SYNC, 0, 1);
    flush();
    n_checks++; if (obs_q[6*FB+7][20:18] !== {ST_LOCKED, 1'b1} || obs_q[6*FB+7][7:0] !== 8'd1) begin
      n_fail++; $display("FAIL corrupt_decision: got %h expected state 10 locked 1 err 01", obs_q[6*FB+7]);
    end
    k = 0;
    for (int i = from; i < obs_q.size(); i++) if (obs_q[i][17]) k++;
    n_checks++; if (k != 32) begin n_fail++; $display("FAIL corrupt_byte_count: got %0d expected 32", k); end
    n_checks++; if (locked !== 1'b1 || sync_err_cnt !== 8'd1) begin n_fail++; $display("FAIL corrupt_final: got locked %b err %h expected locked 1 err 01", locked, sync_err_cnt); end
    run_model();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL corrupt_nbits: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = from; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL corrupt_trace bit %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_loss_of_lock();
    int k, late;
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(SYNC, 0, 1);
    send_frame(BAD_SYNC, 0, 1);
    send_frame(BAD_SYNC, 0, 1);
    flush();
    n_checks++; if (obs_q[3*FB+7][20:18] !== {ST_LOCKED, 1'b1} || obs_q[3*FB+7][7:0] !== 8'd1) begin
      n_fail++; $display("FAIL loss_first_miss: got %h expected state 10 locked 1 err 01", obs_q[3*FB+7]);
    end
    n_checks++; if (obs_q[4*FB+7][20:18] !== {ST_HUNT, 1'b0} || obs_q[4*FB+7][7:0] !== 8'd2) begin
      n_fail++; $display("FAIL loss_second_miss: got %h expected state 00 locked 0 err 02", obs_q[4*FB+7]);
    end
    k = 0; late = 0;
    foreach (obs_q[i]) if (obs_q[i][17]) begin k++; if (i > 4*FB+7) late++; end
    n_checks++; if (k != 32) begin n_fail++; $display("FAIL loss_byte_count: got %0d expected 32", k); end
    n_checks++; if (late != 0) begin n_fail++; $display("FAIL loss_bytes_after_drop: got %0d expected 0", late); end
    n_checks++; if (state !== ST_HUNT || sync_err_cnt !== 8'd2) begin n_fail++; $display("FAIL loss_final: got state %b err %h expected 00 02", state, sync_err_cnt); end
    run_model();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL loss_nbits: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL loss_trace bit %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_false_sync();
    int lk;
    do_reset();
    send_byte(SYNC, 1);
    for (int j = 0; j < 2 * FB / 8; j++) send_byte(8'h00, 1);
    flush();
    n_checks++; if (obs_q[7][20:19] !== ST_VERIFY) begin n_fail++; $display("FAIL false_hit: got %b expected %b", obs_q[7][20:19], ST_VERIFY); end
    n_checks++; if (obs_q[FB+7][20:19] !== ST_HUNT) begin n_fail++; $display("FAIL false_reject: got %b expected %b", obs_q[FB+7][20:19], ST_HUNT); end
    lk = 0;
    foreach (obs_q[i]) if (obs_q[i][18] !== 1'b0) lk++;
    n_checks++; if (lk != 0) begin n_fail++; $display("FAIL false_locked: got %0d locked bits expected 0", lk); end
    run_model();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL false_nbits: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL false_trace bit %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got_q[$];
    do_reset();
    for (int f = 0; f < 6; f++) send_frame(SYNC, 0, 0);
    flush();
    foreach (obs_q[i]) if (obs_q[i][17]) got_q.push_back(obs_q[i][15:8]);
    n_checks++; if (got_q.size() != ref_bytes_q.size()) begin n_fail++; $display("FAIL b2b_byte_count: got %0d expected %0d", got_q.size(), ref_bytes_q.size()); end
    for (int i = 0; i < got_q.size() && i < ref_bytes_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== ref_bytes_q[i]) begin n_fail++; $display("FAIL b2b_byte %0d: got %h expected %h", i, got_q[i], ref_bytes_q[i]); end
    end
    run_model();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_nbits: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_trace bit %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(SYNC, 0, 0);
    send_byte(SYNC, 0);
    for (int j = 0; j < 5; j++) send_byte(8'(j), 0);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 0);
    @(posedge clk);
    #3;
    n_checks++; if (locked !== 1'b1 || byte_out !== 8'h04) begin n_fail++; $display("FAIL mid_pre_reset: got locked %b byte %h expected 1 04", locked, byte_out); end
    rst = 1'b1;
    sample_en = 1'b0;
    #1;
    n_checks++; if ({byte_out, byte_valid, sof, locked, state, sync_err_cnt} !== 21'h0) begin
      n_fail++; $display("FAIL mid_async_reset: got byte %h bv %b sof %b locked %b state %b err %h expected all 0", byte_out, byte_valid, sof, locked, state, sync_err_cnt);
    end
    bits_q.delete();
    obs_q.delete();
    stray_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int f = 0; f < 2; f++) send_frame(SYNC, 0, 0);
    flush();
    n_checks++; if (obs_q[7][20:19] !== ST_VERIFY) begin n_fail++; $display("FAIL mid_reacquire: got %b expected %b", obs_q[7][20:19], ST_VERIFY); end
    n_checks++; if (locked !== 1'b0 || state !== ST_VERIFY) begin n_fail++; $display("FAIL mid_not_locked: got locked %b state %b expected 0 01", locked, state); end
    run_model();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_nbits: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_trace bit %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] s;
    do_reset();
    for (int f = 0; f < 10; f++) begin
      s = SYNC;
      if (f >= 3 && $urandom_range(0, 3) == 0) s = SYNC ^ (8'h01 << $urandom_range(0, 7));
      send_frame(s, 1, -1);
    end
    flush();
    run_model();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_nbits: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_trace bit %0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_checks++; if (stray_cnt != 0) begin n_fail++; $display("FAIL rand_stray_pulse: got %0d expected 0", stray_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lock_and_payload();
    test_single_corrupt();
    test_loss_of_lock();
    test_false_sync();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
